// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - iterative restoring divider for RV32M DIV/DIVU/REM/REMU
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] mag_b;
  logic             sign_q;
  logic             sign_r;
  logic             sel_rem;
  logic             div_zero;

  logic             is_signed;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // The shifted partial remainder keeps its carry-out bit so divisors above
  // 2^(WIDTH-1) still compare correctly.
  always_comb begin
    is_signed = ~op[0];
    mag_a_in  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b_in  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    rem_shift = {rem, quo[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, mag_b};
    fits      = rem_shift >= {1'b0, mag_b};
    rem_next  = fits ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    q_final   = div_zero ? '1 : (sign_q ? -quo : quo);
    r_final   = sign_r ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      mag_b    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      sel_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            quo      <= mag_a_in;
            rem      <= '0;
            mag_b    <= mag_b_in;
            sign_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r   <= is_signed & dividend[WIDTH-1];
            sel_rem  <= op[1];
            div_zero <= (divisor == '0);
            count    <= CW'(WIDTH);
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          rem   <= rem_next;
          quo   <= {quo[WIDTH-2:0], fits};
          count <= count - CW'(1);
          if (count == CW'(1))
            state <= FIX;
        end
        FIX: begin
          result <= sel_rem ? r_final : q_final;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - scoreboard testbench for iter_divider
module tb_iter_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];

  iter_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V reference semantics
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'b00:   if (b == 0) return '1; else if (ovf) return a; else return $signed(a) / $signed(b);
      2'b01:   if (b == 0) return '1; else return a / b;
      2'b10:   if (b == 0) return a; else if (ovf) return '0; else return $signed(a) % $signed(b);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // Called at a negedge; returns at the following negedge with start low.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; dividend = a; divisor = b; start = 1'b1;
    sb.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); dividend = $urandom; divisor = $urandom;
  endtask

  // Waits for done; edges counts posedges since the one that sampled start.
  task automatic collect(output logic [W-1:0] got, output int edges, output int busy_n, output bit ok);
    int n;
    n = 1; busy_n = 0; ok = 1'b0; got = 'x;
    while (n < 100) begin
      if (busy) busy_n++;
      if (done) begin ok = 1'b1; got = result; break; end
      @(negedge clk);
      n++;
    end
    edges = n - 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
  endtask

  task automatic test_latency();
    logic [W-1:0] got, exp;
    int edges, busy_n;
    bit ok;
    issue(2'b01, 100, 7);
    collect(got, edges, busy_n, ok);
    exp = sb.pop_front();
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL divu_100_7 got %h want %h", got, exp); end
    checks++; if (edges != W + 1) begin errors++; $display("FAIL latency got %0d want %0d", edges, W + 1); end
    checks++; if (busy_n != W + 1) begin errors++; $display("FAIL busy_cycles got %0d want %0d", busy_n, W + 1); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", done); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL result_hold got %h want 0000000e", result); end
  endtask

  task automatic test_table();
    logic [1:0]   t_op[14];
    logic [W-1:0] t_a[14];
    logic [W-1:0] t_b[14];
    logic [W-1:0] t_e[14];
    logic [W-1:0] got, exp;
    int edges, busy_n;
    bit ok;
    t_op = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b11};
    t_a  = '{-32'sd7, -32'sd7, 32'd7, 32'd5, 32'd5, -32'sd5, -32'sd5, 32'h8000_0000, 32'h8000_0000,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    t_b  = '{32'd2, 32'd2, -32'sd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'd1, 32'h8000_0001, 32'h8000_0001, 32'd0, 32'd9};
    t_e  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB,
             32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 14; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      collect(got, edges, busy_n, ok);
      exp = sb.pop_front();
      checks++; if (!ok || got !== t_e[i]) begin errors++; $display("FAIL case_%0d got %h want %h", i, got, t_e[i]); end
      checks++; if (exp !== t_e[i]) begin errors++; $display("FAIL model_%0d got %h want %h", i, exp, t_e[i]); end
      checks++; if (edges != W + 1) begin errors++; $display("FAIL case_%0d_latency got %0d want %0d", i, edges, W + 1); end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] got, exp;
    int edges, busy_n;
    bit ok, spurious;
    issue(2'b01, 32'hFFFF_FFFF, 32'd1);
    repeat (4) @(negedge clk);
    op = 2'b00; dividend = 32'd7; divisor = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(got, edges, busy_n, ok);
    exp = sb.pop_front();
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL busy_ignore got %h want %h", got, exp); end
    checks++; if (edges != W + 1 - 5) begin errors++; $display("FAIL busy_ignore_latency got %0d want %0d", edges, W - 4); end
    spurious = 1'b0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (done || busy) spurious = 1'b1;
    end
    checks++; if (spurious) begin errors++; $display("FAIL busy_ignore_extra got activity want none"); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got, exp;
    int edges, busy_n;
    bit ok;
    issue(2'b00, -32'sd100, 32'd7);
    for (int i = 0; i < 8; i++) begin
      collect(got, edges, busy_n, ok);
      exp = sb.pop_front();
      checks++; if (!ok || got !== exp) begin errors++; $display("FAIL b2b_%0d got %h want %h", i, got, exp); end
      if (i < 7) begin
        // start in the same cycle as done
        if (i == 2) issue(2'b01, 32'hFFFF_FFFE, 32'h8000_0001);
        else issue(2'($urandom_range(0, 3)), $urandom, $urandom >> $urandom_range(0, 31));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] got, exp;
    int edges, busy_n;
    bit ok, spurious;
    issue(2'b01, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL midrst_result got %h want 0", result); end
    spurious = 1'b0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (done) spurious = 1'b1;
    end
    checks++; if (spurious) begin errors++; $display("FAIL midrst_no_done got done want none"); end
    issue(2'b10, -32'sd1000, 32'd3);
    collect(got, edges, busy_n, ok);
    exp = sb.pop_front();
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL midrst_after got %h want %h", got, exp); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_table();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
